pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage core. It is the generalised successor to the fixed-field stage registers, intended to replace ID/EX, EX/MEM and MEM/WB. It carries a control field and a payload field with a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, synchronous flush for bubble insertion, and a saturating stall counter. Control bits are forced to zero whenever the stage holds a bubble, so write/memory enables never leak downstream.

---
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// Control bits are masked to zero on bubbles. A saturating counter tracks downstream stalls.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 143,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, pop;

  assign acc = in_valid & in_ready;
  assign pop = main_valid & out_ready;

  // The skid entry is only occupied while main is occupied, so a full stage is
  // exactly skid_valid. That keeps in_ready a pure register output.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  // NOTE: every register here is clocked state, so only non-blocking assignments
  // are used; the data registers are reset too because out_data is defined after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data registers keep their contents; an entry accepted now is dropped.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        if (acc) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (acc) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, checked against a
// queue-based model of a two-deep FIFO stage. A second instance with a 4-bit counter shares the stimulus.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 143;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: the stage is a FIFO of capacity two.
  ent_t          q[$];
  logic [DW-1:0] last_data;
  int            cnt16, cnt4;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] da, db, dc;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic check_model();
    logic [CW-1:0] ec;
    ec = (q.size() > 0) ? q[0].c : '0;
    check("in_ready",   DW'(in_ready),   DW'(q.size() < 2));
    check("out_valid",  DW'(out_valid),  DW'(q.size() > 0));
    check("out_ctrl",   DW'(out_ctrl),   DW'(ec));
    check("out_data",   out_data,        last_data);
    check("stall_cnt",  DW'(stall_cnt),  DW'(cnt16));
    check("stall_cnt4", DW'(stall_cnt4), DW'(cnt4));
  endtask

  // Apply one cycle of stimulus: check current outputs, clock, advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit   acc, pop;
    ent_t e;
    rst = r; flush = f; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    @(negedge clk);
    check_model();
    acc = iv && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      last_data = '0;
      cnt16 = 0;
      cnt4 = 0;
    end else begin
      if ((q.size() > 0) && !ordy) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (f) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.c = c;
          e.d = d;
          q.push_back(e);
        end
        if (q.size() > 0) last_data = q[0].d;
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, ordy, '0, '0);
  endtask

  initial begin
    q.delete();
    last_data = '0;
    cnt16 = 0;
    cnt4 = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'hFF; in_data = '1;

    // Reset with a valid upstream entry held: nothing may leak through.
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, rand_data());
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, rand_data());
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_ctrl",  DW'(out_ctrl),  '0);
    check("rst_out_data",  out_data,       '0);
    check("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("rst_stall_cnt", DW'(stall_cnt), '0);

    // Streaming at full rate.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, rand_data());
    check("stream_a", DW'(out_ctrl), DW'(8'h01));
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h02, rand_data());
    check("stream_b", DW'(out_ctrl), DW'(8'h02));
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, rand_data());
    check("stream_c", DW'(out_ctrl), DW'(8'h03));
    check("stream_ready", DW'(in_ready), DW'(1'b1));
    idle(1'b1);
    check("stream_drained", DW'(out_valid), '0);

    // Back-pressure fills the skid entry, then drains in order.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    da = rand_data();
    db = rand_data();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, da);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, db);
    check("bp_full_ready", DW'(in_ready), '0);
    check("bp_head_ctrl",  DW'(out_ctrl), DW'(8'h0A));
    idle(1'b0);
    check("bp_stalls", DW'(stall_cnt), DW'(16'd2));
    idle(1'b1);
    check("bp_second_ctrl", DW'(out_ctrl), DW'(8'h0B));
    check("bp_second_data", out_data, db);
    check("bp_ready_back", DW'(in_ready), DW'(1'b1));
    idle(1'b1);
    check("bp_empty", DW'(out_valid), '0);

    // Flush while full, with a new entry offered in the same cycle.
    da = rand_data();
    dc = rand_data();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, da);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h12, rand_data());
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h13, dc);
    check("fl_valid", DW'(out_valid), '0);
    check("fl_ctrl",  DW'(out_ctrl),  '0);
    check("fl_ready", DW'(in_ready),  DW'(1'b1));
    check("fl_data_held", out_data, da);
    idle(1'b1);
    check("fl_c_dropped", DW'(out_valid), '0);

    // Flush and reset together while full: reset wins.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h21, rand_data());
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h22, rand_data());
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h23, rand_data());
    check("fr_valid", DW'(out_valid), '0);
    check("fr_data",  out_data,       '0);
    check("fr_cnt",   DW'(stall_cnt), '0);
    check("fr_ready", DW'(in_ready),  DW'(1'b1));

    // Saturation of the 4-bit counter.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h31, rand_data());
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("sat_cnt4",  DW'(stall_cnt4), DW'(4'd15));
    check("sat_cnt16", DW'(stall_cnt),  DW'(16'd20));
    idle(1'b0);
    check("sat_hold", DW'(stall_cnt4), DW'(4'd15));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6),
           CW'($urandom), rand_data());
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
